decoder_mul_share_arbiter: RTL

//   Shares one 18s x 17u multiplier (26-bit truncated product) among NREQ requesters in the decoder datapath.

---
 rtl/decoder_mul_share_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/decoder_mul_share_arbiter.sv
// Purpose : one 18s x 17u multiplier (26-bit truncated product) shared round-robin by NREQ requesters.
// Latency : transfer at edge k -> res_vld high after edge k+1 (S0 operand reg, S1 product reg).
// Backpr. : res_rdy low freezes S1; S0 then fills and every req_rdy drops. At most 2 entries in flight.
//
// Ports:
//   ap_clk, ap_rst_n     clock / async active-low reset
//   req_vld/req_rdy      per-requester handshake, req_rdy is one-hot or zero
//   req_a, req_b         packed operands, requester i at [i*W +: W]
//   res_vld/res_rdy      result handshake
//   res_id, res_data     owning requester index and truncated product
//   busy                 S0 or S1 holds a valid entry
module decoder_mul_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 17,
  parameter int P_WIDTH = 26,
  parameter int IDW     = 2
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NREQ-1:0]            req_vld,
  output logic [NREQ-1:0]            req_rdy,
  input  logic [NREQ*A_WIDTH-1:0]    req_a,
  input  logic [NREQ*B_WIDTH-1:0]    req_b,
  output logic                       res_vld,
  input  logic                       res_rdy,
  output logic [IDW-1:0]             res_id,
  output logic [P_WIDTH-1:0]         res_data,
  output logic                       busy
);

  localparam int FULL_W = A_WIDTH + B_WIDTH + 1;

  generate
    if (NREQ < 2 || IDW < $clog2(NREQ) || P_WIDTH > FULL_W) begin : g_bad_param
      $error("decoder_mul_share_arbiter: illegal parameter combination");
    end
  endgenerate

  // State
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic               s0_vld_q, s0_vld_d;
  logic [A_WIDTH-1:0] s0_a_q, s0_a_d;
  logic [B_WIDTH-1:0] s0_b_q, s0_b_d;
  logic [IDW-1:0]     s0_id_q, s0_id_d;
  logic               s1_vld_q, s1_vld_d;
  logic [IDW-1:0]     res_id_q, res_id_d;
  logic [P_WIDTH-1:0] res_data_q, res_data_d;

  // Combinational
  logic               s1_adv, s0_adv;
  logic               found;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     cand;
  logic               xfer;
  logic [A_WIDTH-1:0] a_sel;
  logic [B_WIDTH-1:0] b_sel;
  logic signed [FULL_W-1:0] a_ext, b_ext, prod_full;

  assign s1_adv = !s1_vld_q || res_rdy;
  assign s0_adv = !s0_vld_q || s1_adv;

  // Round-robin search starting at rr_ptr, wrapping at NREQ-1 -> 0.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && req_vld[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign xfer = found && s0_adv;

  // Held at zero while reset is asserted so no requester sees an accept.
  always_comb begin
    req_rdy = '0;
    if (xfer && ap_rst_n) begin
      req_rdy[win] = 1'b1;
    end
  end

  assign a_sel = req_a[win*A_WIDTH +: A_WIDTH];
  assign b_sel = req_b[win*B_WIDTH +: B_WIDTH];

  // A sign-extended, B zero-extended, multiplied at full width, then truncated.
  assign a_ext     = {{(B_WIDTH+1){s0_a_q[A_WIDTH-1]}}, s0_a_q};
  assign b_ext     = {{(A_WIDTH+1){1'b0}}, s0_b_q};
  assign prod_full = a_ext * b_ext;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
    end
  end

  always_comb begin
    s0_vld_d = s0_vld_q;
    s0_a_d   = s0_a_q;
    s0_b_d   = s0_b_q;
    s0_id_d  = s0_id_q;
    if (xfer) begin
      s0_vld_d = 1'b1;
      s0_a_d   = a_sel;
      s0_b_d   = b_sel;
      s0_id_d  = win;
    end else if (s1_adv) begin
      s0_vld_d = 1'b0;
    end
  end

  // Result registers only move when S1 advances, so a stalled result stays stable.
  always_comb begin
    s1_vld_d   = s1_vld_q;
    res_id_d   = res_id_q;
    res_data_d = res_data_q;
    if (s1_adv) begin
      s1_vld_d = s0_vld_q;
      if (s0_vld_q) begin
        res_data_d = prod_full[P_WIDTH-1:0];
        res_id_d   = s0_id_q;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr_q   <= '0;
      s0_vld_q   <= 1'b0;
      s0_a_q     <= '0;
      s0_b_q     <= '0;
      s0_id_q    <= '0;
      s1_vld_q   <= 1'b0;
      res_id_q   <= '0;
      res_data_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      s0_vld_q   <= s0_vld_d;
      s0_a_q     <= s0_a_d;
      s0_b_q     <= s0_b_d;
      s0_id_q    <= s0_id_d;
      s1_vld_q   <= s1_vld_d;
      res_id_q   <= res_id_d;
      res_data_q <= res_data_d;
    end
  end

  assign res_vld  = s1_vld_q;
  assign res_id   = res_id_q;
  assign res_data = res_data_q;
  assign busy     = s0_vld_q || s1_vld_q;

endmodule
